// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster timing constants and colour constants, used by this
// timing driver and by the colour stage that feeds it.
package video_timing_pkg;

  localparam int RGB_W = 24;

  localparam logic [10:0] H_SYNC  = 11'd40;
  localparam logic [10:0] H_BACK  = 11'd220;
  localparam logic [10:0] H_DISP  = 11'd1280;
  localparam logic [10:0] H_FRONT = 11'd110;
  localparam logic [10:0] H_TOTAL = 11'd1650;

  localparam logic [10:0] V_SYNC  = 11'd5;
  localparam logic [10:0] V_BACK  = 11'd20;
  localparam logic [10:0] V_DISP  = 11'd720;
  localparam logic [10:0] V_FRONT = 11'd5;
  localparam logic [10:0] V_TOTAL = 11'd750;

  localparam logic SYNC_POL = 1'b1;

  localparam logic [RGB_W-1:0] BLACK = 24'h000000;
  localparam logic [RGB_W-1:0] WHITE = 24'hFFFFFF;
  localparam logic [RGB_W-1:0] BLUE  = 24'h0000FF;

  // First active count of a line or frame: sync width plus back porch.
  function automatic logic [10:0] active_start(input logic [10:0] sync_len,
                                               input logic [10:0] back_len);
    return sync_len + back_len;
  endfunction

endpackage

// File: rtl/video_timing_driver_sync_window_counter.sv
// Generic wrapping counter for one raster axis. Holds at zero until run is
// set, advances on en, and decodes the sync pulse and active window flags.
module sync_window_counter #(
  parameter int           W         = 11,
  parameter logic [W-1:0] TOTAL     = 11'd1650,
  parameter logic [W-1:0] SYNC      = 11'd40,
  parameter logic [W-1:0] ACT_START = 11'd260,
  parameter logic [W-1:0] ACT_LEN   = 11'd1280
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         last,
  output logic         sync,
  output logic         active
);

  assign last   = (cnt == TOTAL - W'(1));
  assign sync   = (cnt < SYNC);
  assign active = (cnt >= ACT_START) && (cnt < ACT_START + ACT_LEN);

  // Count position along the axis; parked at zero until the raster starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!run)
      cnt <= '0;
    else if (en)
      cnt <= last ? '0 : cnt + W'(1);
  end

endmodule

// File: rtl/video_timing_driver.sv
// 1280x720@60 raster timing generator. Requests pixels one clock ahead of the
// display-enable window and merges the returned colour into HS/VS/DE/RGB.
module video_timing_driver
  import video_timing_pkg::*;
#(
  parameter logic [10:0] HSYNC  = H_SYNC,
  parameter logic [10:0] HBACK  = H_BACK,
  parameter logic [10:0] HDISP  = H_DISP,
  parameter logic [10:0] HFRONT = H_FRONT,
  parameter logic [10:0] VSYNC  = V_SYNC,
  parameter logic [10:0] VBACK  = V_BACK,
  parameter logic [10:0] VDISP  = V_DISP,
  parameter logic [10:0] VFRONT = V_FRONT,
  parameter logic        POL    = SYNC_POL
) (
  input  logic             pixel_clk,
  input  logic             sys_rst_n,
  input  logic [RGB_W-1:0] pixel_data,
  output logic [10:0]      pixel_xpos,
  output logic [10:0]      pixel_ypos,
  output logic             data_req,
  output logic             video_hs,
  output logic             video_vs,
  output logic             video_de,
  output logic [RGB_W-1:0] video_rgb,
  output logic             frame_start
);

  localparam logic [10:0] HTOTAL = HSYNC + HBACK + HDISP + HFRONT;
  localparam logic [10:0] VTOTAL = VSYNC + VBACK + VDISP + VFRONT;
  localparam logic [10:0] HA     = active_start(HSYNC, HBACK);
  localparam logic [10:0] VA     = active_start(VSYNC, VBACK);
  localparam logic [10:0] HREQ_LO = HA - 11'd1;
  localparam logic [10:0] HREQ_HI = HA + HDISP - 11'd1;

  logic        run;
  logic [10:0] h_cnt, v_cnt;
  logic        h_last, h_sync, h_active;
  logic        v_last, v_sync, v_active;
  logic        h_req;

  // One idle edge after reset release before the raster begins at (0,0).
  always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      run <= 1'b0;
    else
      run <= 1'b1;
  end

  sync_window_counter #(
    .W(11), .TOTAL(HTOTAL), .SYNC(HSYNC), .ACT_START(HA), .ACT_LEN(HDISP)
  ) u_h_counter (
    .clk(pixel_clk), .rst_n(sys_rst_n), .run(run), .en(1'b1),
    .cnt(h_cnt), .last(h_last), .sync(h_sync), .active(h_active)
  );

  sync_window_counter #(
    .W(11), .TOTAL(VTOTAL), .SYNC(VSYNC), .ACT_START(VA), .ACT_LEN(VDISP)
  ) u_v_counter (
    .clk(pixel_clk), .rst_n(sys_rst_n), .run(run), .en(h_last),
    .cnt(v_cnt), .last(v_last), .sync(v_sync), .active(v_active)
  );

  assign h_req = (h_cnt >= HREQ_LO) && (h_cnt < HREQ_HI);

  // Output decode from the registered counters; everything idles while not running.
  always_comb begin
    video_hs    = !POL;
    video_vs    = !POL;
    video_de    = 1'b0;
    data_req    = 1'b0;
    frame_start = 1'b0;
    pixel_xpos  = '0;
    pixel_ypos  = '0;
    video_rgb   = BLACK;
    if (run) begin
      video_hs    = h_sync ? POL : !POL;
      video_vs    = v_sync ? POL : !POL;
      video_de    = h_active && v_active;
      data_req    = h_req && v_active;
      frame_start = (h_cnt == 11'd0) && (v_cnt == 11'd0);
      if (data_req) begin
        pixel_xpos = h_cnt - HREQ_LO;
        pixel_ypos = v_cnt - VA;
      end
      if (video_de)
        video_rgb = pixel_data;
    end
  end

endmodule

// File: tb/tb_video_timing_driver.sv
// Self-checking bench for video_timing_driver using a reduced raster so that
// several whole frames fit in a short run. A linear frame-position model
// derives every expected output with plain div/mod arithmetic.
module tb_video_timing_driver;

  localparam logic [10:0] P_HS = 11'd4,  P_HB = 11'd5, P_HD = 11'd12, P_HF = 11'd3;
  localparam logic [10:0] P_VS = 11'd2,  P_VB = 11'd3, P_VD = 11'd6,  P_VF = 11'd2;
  localparam int HT = 24, VT = 13, FRAME = HT * VT;
  localparam int HS_I = 4, HD_I = 12, VS_I = 2, VD_I = 6;
  localparam int HA = 9, VA = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] pixel_data = '0;
  logic [10:0] pixel_xpos, pixel_ypos;
  logic        data_req, video_hs, video_vs, video_de, frame_start;
  logic [23:0] video_rgb;

  int checks = 0;
  int errors = 0;
  int mode = 0;          // colour stage: 0 = {ypos,xpos}, 1 = white, 2 = random
  bit m_run = 1'b0;
  int m_t = 0;

  video_timing_driver #(
    .HSYNC(P_HS), .HBACK(P_HB), .HDISP(P_HD), .HFRONT(P_HF),
    .VSYNC(P_VS), .VBACK(P_VB), .VDISP(P_VD), .VFRONT(P_VF), .POL(1'b1)
  ) dut (
    .pixel_clk(clk), .sys_rst_n(rst_n), .pixel_data(pixel_data),
    .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos), .data_req(data_req),
    .video_hs(video_hs), .video_vs(video_vs), .video_de(video_de),
    .video_rgb(video_rgb), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Colour stage model: one-cycle registered response to the request.
  always @(posedge clk) begin
    case (mode)
      0:       pixel_data <= {2'b00, pixel_ypos, pixel_xpos};
      1:       pixel_data <= 24'hFFFFFF;
      default: pixel_data <= 24'($urandom);
    endcase
  end

  // Reference position: linear clock index within the frame.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      m_t   <= 0;
    end else if (!m_run) begin
      m_run <= 1'b1;
    end else begin
      m_t <= (m_t + 1) % FRAME;
    end
  end

  function automatic logic [50:0] expect_vec(input int t, input bit run,
                                             input logic [23:0] pd, input int md);
    int h, v;
    logic hs, vs, de, req, fs;
    logic [10:0] x, y;
    logic [23:0] rgb;
    h = t % HT;
    v = t / HT;
    hs = 0; vs = 0; de = 0; req = 0; fs = 0; x = '0; y = '0; rgb = '0;
    if (run) begin
      hs  = (h < HS_I);
      vs  = (v < VS_I);
      de  = (h >= HA) && (h < HA + HD_I) && (v >= VA) && (v < VA + VD_I);
      req = (h >= HA - 1) && (h < HA + HD_I - 1) && (v >= VA) && (v < VA + VD_I);
      fs  = (t == 0);
      if (req) begin
        x = 11'(h - HA + 1);
        y = 11'(v - VA);
      end
      if (de) rgb = (md == 0) ? {2'b00, 11'(v - VA), 11'(h - HA)} : pd;
    end
    return {hs, vs, de, req, fs, x, y, rgb};
  endfunction

  function automatic logic [50:0] actual_vec();
    return {video_hs, video_vs, video_de, data_req, frame_start,
            pixel_xpos, pixel_ypos, video_rgb};
  endfunction

  task automatic wait_frame_start();
    bit found = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      if (frame_start) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_frame_start: frame_start=0 after %0d cycles, required a pulse", 2 * FRAME + 4);
    end
  endtask

  task automatic test_reset();
    logic [50:0] act;
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      act = actual_vec();
      checks++;
      if (act !== 51'd0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs=%h, required=0", i, act);
      end
    end
    rst_n = 1'b1;
    #1;
    act = actual_vec();
    checks++;
    if (act !== 51'd0) begin
      errors++;
      $display("FAIL release_idle: outputs=%h, required=0", act);
    end
    @(negedge clk);
    checks++;
    if (frame_start !== 1'b1 || video_hs !== 1'b1) begin
      errors++;
      $display("FAIL first_cycle: frame_start=%b hs=%b, required 1 1", frame_start, video_hs);
    end
  endtask

  task automatic test_line_timing();
    int hs_hi = 0, rise = -1, de_cnt = 0, de_first = -1;
    logic prev;
    for (int i = 1; i <= 2 * HT; i++) begin
      if (video_hs) hs_hi++;
      prev = video_hs;
      @(negedge clk);
      if (video_hs && !prev) begin rise = i; break; end
    end
    checks++;
    if (hs_hi != HS_I) begin
      errors++;
      $display("FAIL hs_width: got %0d clocks, required %0d", hs_hi, HS_I);
    end
    checks++;
    if (rise != HT) begin
      errors++;
      $display("FAIL line_period: got %0d clocks, required %0d", rise, HT);
    end
    repeat (VA * HT) @(negedge clk);
    for (int i = 0; i < HT; i++) begin
      if (video_de) begin
        de_cnt++;
        if (de_first < 0) de_first = i;
      end
      @(negedge clk);
    end
    checks++;
    if (de_cnt != HD_I || de_first != HA) begin
      errors++;
      $display("FAIL de_window: got %0d clocks from h=%0d, required %0d from h=%0d",
               de_cnt, de_first, HD_I, HA);
    end
  endtask

  task automatic test_request_alignment();
    int first_req = -1, last_x = -1;
    logic [10:0] first_x = '1, first_y = '1;
    logic [50:0] act, exp_v;
    mode = 0;
    wait_frame_start();
    for (int idx = 0; idx < FRAME; idx++) begin
      act = actual_vec();
      exp_v = expect_vec(m_t, m_run, pixel_data, mode);
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL align cycle %0d: outputs=%h, required=%h", idx, act, exp_v);
      end
      if (data_req) begin
        if (first_req < 0) begin
          first_req = idx;
          first_x = pixel_xpos;
          first_y = pixel_ypos;
        end
        last_x = int'(pixel_xpos);
      end
      @(negedge clk);
    end
    checks++;
    if (first_req != VA * HT + HA - 1 || first_x !== 11'd0 || first_y !== 11'd0) begin
      errors++;
      $display("FAIL first_req: at %0d x=%0d y=%0d, required at %0d x=0 y=0",
               first_req, first_x, first_y, VA * HT + HA - 1);
    end
    checks++;
    if (last_x != HD_I - 1) begin
      errors++;
      $display("FAIL last_req_x: got %0d, required %0d", last_x, HD_I - 1);
    end
  endtask

  task automatic test_frame_timing();
    int vs_hi = 0, bad_de = 0, fs_mid = 0, line;
    wait_frame_start();
    for (int idx = 0; idx < FRAME; idx++) begin
      line = idx / HT;
      if (video_vs) vs_hi++;
      if (video_de && (line < VA || line >= VA + VD_I)) bad_de++;
      if (idx > 0 && frame_start) fs_mid++;
      @(negedge clk);
    end
    checks++;
    if (vs_hi != VS_I * HT) begin
      errors++;
      $display("FAIL vs_width: got %0d clocks, required %0d", vs_hi, VS_I * HT);
    end
    checks++;
    if (bad_de != 0) begin
      errors++;
      $display("FAIL de_blank_lines: got %0d de clocks outside active lines, required 0", bad_de);
    end
    checks++;
    if (frame_start !== 1'b1 || fs_mid != 0) begin
      errors++;
      $display("FAIL frame_period: end pulse=%b extra pulses=%0d, required 1 and 0", frame_start, fs_mid);
    end
  endtask

  task automatic test_blanking(input int md);
    logic [50:0] act, exp_v;
    mode = md;
    wait_frame_start();
    for (int idx = 0; idx < FRAME; idx++) begin
      act = actual_vec();
      exp_v = expect_vec(m_t, m_run, pixel_data, mode);
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL blanking mode %0d cycle %0d: outputs=%h, required=%h", md, idx, act, exp_v);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_mid_frame_reset(input int target);
    bit found = 0;
    logic [50:0] act, exp_v;
    mode = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge clk);
      if (m_run && m_t == target) begin found = 1; break; end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_target: position %0d not reached, required reached", target);
    end
    rst_n = 1'b0;
    #1;
    act = actual_vec();
    checks++;
    if (act !== 51'd0) begin
      errors++;
      $display("FAIL reset_immediate at %0d: outputs=%h, required=0", target, act);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    act = actual_vec();
    checks++;
    if (act !== 51'd0) begin
      errors++;
      $display("FAIL reset_idle_cycle: outputs=%h, required=0", act);
    end
    @(negedge clk);
    for (int idx = 0; idx <= FRAME; idx++) begin
      act = actual_vec();
      exp_v = expect_vec(m_t, m_run, pixel_data, mode);
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL post_reset cycle %0d: outputs=%h, required=%h", idx, act, exp_v);
      end
      if ((idx == 0 || idx == FRAME) && frame_start !== 1'b1) begin
        errors++;
        $display("FAIL post_reset_fs cycle %0d: frame_start=%b, required 1", idx, frame_start);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_request_alignment();
    test_frame_timing();
    test_blanking(1);
    test_blanking(2);
    test_mid_frame_reset(7 * HT + 15);
    test_mid_frame_reset(int'($urandom_range(FRAME - 1, 1)));
    test_request_alignment();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
